// File: rtl/div_unit_pkg.sv
// Shared execute-stage definitions: ALU and divider operation encodings,
// divider FSM states, the divider result latency, and op classification helpers.
package div_unit_pkg;

  localparam int XLEN        = 32;
  // Accept edge -> resp_valid: WIDTH CALC cycles, one FIXUP, then DONE.
  localparam int DIV_LATENCY = XLEN + 2;

  typedef enum logic [1:0] {
    ADD_ADD  = 2'd0,
    ADD_SUB  = 2'd1,
    ADD_SLT  = 2'd2,
    ADD_SLTU = 2'd3
  } adderOp_t;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } divOp_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } div_state_t;

  function automatic logic is_signed_div(input divOp_t op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic is_rem_op(input divOp_t op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring division iteration (combinational).
//   rem       [WIDTH:0]   partial remainder before the step
//   quot      [WIDTH-1:0] dividend/quotient shift register before the step
//   divisor   [WIDTH-1:0] divisor magnitude
//   rem_next  [WIDTH:0]   partial remainder after the step
//   quot_next [WIDTH-1:0] quotient register shifted left with the new bit
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quot_next
);

  // The partial remainder always stays below the divisor, so rem[WIDTH] is
  // zero in practice; carrying it as a guard bit keeps the step exact for any
  // input, and the borrow lands in the extra top bit.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem, quot[WIDTH-1]};
  assign trial   = shifted - {2'b00, divisor};

  always_comb begin
    rem_next  = shifted[WIDTH:0];
    quot_next = {quot[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      rem_next  = trial[WIDTH:0];
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_op, req_a (dividend), req_b (divisor)
//   kill                     abort the in-flight operation, no response issued
//   resp_valid/resp_ready    response handshake; resp_data = quotient or remainder
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  divOp_t           req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             kill,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data
);

  localparam int               CNT_W   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] divisor;
  logic             op_rem;
  logic             op_signed;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quot_next;

  logic             req_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH-1:0] fix_res;

  assign req_ready = (state == S_IDLE) && !rst;

  // Operand conditioning. |MIN_INT| wraps to MIN_INT, which is the right
  // magnitude once the datapath treats it as unsigned.
  assign req_signed = is_signed_div(req_op);
  assign a_mag      = (req_signed && req_a[WIDTH-1]) ? neg2c(req_a) : req_a;
  assign b_mag      = (req_signed && req_b[WIDTH-1]) ? neg2c(req_b) : req_b;
  assign b_zero     = (req_b == '0);
  assign ovf        = req_signed && (req_a == MIN_INT) && (req_b == '1);

  // Divide-by-zero and signed overflow skip the iteration entirely.
  always_comb begin
    special_res = '0;
    if (b_zero) special_res = is_rem_op(req_op) ? req_a : '1;
    else        special_res = is_rem_op(req_op) ? '0 : MIN_INT;
  end

  always_comb begin
    fix_res = '0;
    if (op_rem) fix_res = (op_signed && neg_r) ? neg2c(rem[WIDTH-1:0]) : rem[WIDTH-1:0];
    else        fix_res = (op_signed && neg_q) ? neg2c(quot) : quot;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (divisor),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && !kill) begin
            op_rem    <= is_rem_op(req_op);
            op_signed <= req_signed;
            neg_q     <= req_a[WIDTH-1] ^ req_b[WIDTH-1];
            neg_r     <= req_a[WIDTH-1];
            if (b_zero || ovf) begin
              resp_data  <= special_res;
              resp_valid <= 1'b1;
              state      <= S_DONE;
            end else begin
              rem     <= '0;
              quot    <= a_mag;
              divisor <= b_mag;
              cnt     <= CNT_W'(WIDTH);
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            rem  <= rem_next;
            quot <= quot_next;
            cnt  <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            resp_data  <= fix_res;
            resp_valid <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (kill || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  divOp_t      req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_v = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: latency on the rising resp_valid, data on the handshake.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (!prev_v) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp: got=%h expected no response", resp_data);
        end else if (cyc - sb[0].acc != sb[0].lat) begin
          bad++;
          $display("FAIL %s_latency: got=%0d expected=%0d", sb[0].name, cyc - sb[0].acc, sb[0].lat);
        end
      end
      if (resp_ready && sb.size() > 0) begin
        total++;
        if (resp_data !== sb[0].data) begin
          bad++;
          $display("FAIL %s: got=%h expected=%h", sb[0].name, resp_data, sb[0].data);
        end
        void'(sb.pop_front());
      end
    end
    prev_v = resp_valid;
  end

  // Drive one request; returns #1 after the accept edge (start of cycle 1).
  task automatic issue(input divOp_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name,
                       input bit expect_resp);
    int   n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL %s_accept: got req_ready=0 expected 1 within 200 cycles", name);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    if (expect_resp) begin
      e.data = exp; e.lat = lat; e.acc = cyc; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_op = DIV_DIVU; req_a = '0; req_b = '0;
    kill = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Directed vectors with hand-computed results.
    issue(DIV_DIVU, 32'd100,      32'd7,        32'h0000000E, DIV_LATENCY, "divu_100_7", 1);
    issue(DIV_REMU, 32'd100,      32'd7,        32'h00000002, DIV_LATENCY, "remu_100_7", 1);
    issue(DIV_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LATENCY, "div_m7_2",   1);
    issue(DIV_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LATENCY, "rem_m7_2",   1);
    issue(DIV_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LATENCY, "rem_7_m2",   1);
    issue(DIV_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DIV_LATENCY, "divu_max_1", 1);
    issue(DIV_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1,           "divu_5_0",   1);
    issue(DIV_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,           "rem_m5_0",   1);
    issue(DIV_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,           "div_ovf",    1);
    issue(DIV_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,           "rem_ovf",    1);
    issue(DIV_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LATENCY, "div_100_m7", 1);
    drain("vectors");

    // Backpressure in DONE.
    resp_ready = 1'b0;
    issue(DIV_DIVU, 32'd1000, 32'd10, 32'd100, DIV_LATENCY, "bp_divu", 1);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_hold_data", resp_data, 32'd100);
      chk("bp_hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
    issue(DIV_REMU, 32'd1000, 32'd7, 32'd6, DIV_LATENCY, "bp_next_remu", 1);
    chk("bp_next_accepted", {31'd0, req_ready}, 32'd0);
    drain("bp");

    // kill in CALC cycle 10.
    issue(DIV_DIVU, 32'd12345, 32'd11, 32'd0, DIV_LATENCY, "kill_op", 0);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("kill_no_resp", {31'd0, resp_valid}, 32'd0);
    issue(DIV_DIVU, 32'd9, 32'd3, 32'd3, DIV_LATENCY, "kill_then_divu_9_3", 1);
    drain("kill");

    // Reset during FIXUP (cycle 33).
    issue(DIV_DIVU, 32'd500, 32'd5, 32'd0, DIV_LATENCY, "rst_op", 0);
    repeat (32) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_req_ready_after", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    issue(DIV_DIVU, 32'd9, 32'd3, 32'd3, DIV_LATENCY, "rst_then_divu_9_3", 1);
    drain("rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle iterative integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the inverse-operation companion to the single-cycle add/compare datapath, built on the same subtract-and-check-borrow principle but run one quotient bit per cycle. It sits beside the ALU in the execute stage. It takes requests from the issue logic over a valid/ready handshake and returns one result over a second valid/ready handshake.

## Interface
- WIDTH, 32, operand and result width in bits.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; equals (state==IDLE && !rst).
- req_op  input  divOp_t  DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU.
- req_a  input  WIDTH  dividend.
- req_b  input  WIDTH  divisor.
- kill  input  1  abort the in-flight operation (pipeline flush).
- resp_valid  output  1  result available; held until it is taken.
- resp_ready  input  1  consumer takes the result.
- resp_data  output  WIDTH  quotient or remainder.

## Operation
- The FSM has four states: IDLE, CALC, FIXUP and DONE.
- **IDLE:**
  - Accept a request when req_valid && req_ready.
  - On accept, latch the op, the signed flag, neg_q = a_sign^b_sign and neg_r = a_sign.
  - For signed ops, latch |a| and |b|; for unsigned ops, latch a and b raw.
  - |x| uses WIDTH-bit two's-complement negation; |0x80000000| = 0x80000000, which is correct when treated as unsigned.
- **Special cases on accept:** both go directly to DONE with the result preloaded.
  - Divide by zero (b==0): quotient = all ones; remainder = a (raw, unsigned view).
  - Signed overflow (DIV/REM, a==0x80000000, b==all ones): quotient = 0x80000000; remainder = 0.
- **Normal case on accept:** clear rem (WIDTH+1 bits), load quot with the dividend, load the counter with WIDTH, and go to CALC.
- **CALC:** each cycle performs one restoring step.
  - trial = {rem[WIDTH-1:0], quot[WIDTH-1]} − {1'b0, divisor}, computed at WIDTH+1 bits.
  - If trial[WIDTH]==0: rem = trial; shift quot left and shift in 1.
  - Otherwise: rem = {rem[WIDTH-1:0], quot[WIDTH-1]}; shift quot left and shift in 0.
  - Decrement the counter; after the WIDTH-th step, go to FIXUP.
- **FIXUP:**
  - Quotient ops: result = neg_q ? −quot : quot.
  - Remainder ops: result = neg_r ? −rem[WIDTH-1:0] : rem[WIDTH-1:0].
  - Negation applies to signed ops only. Go to DONE.
- **DONE:**
  - resp_valid=1 and resp_data is stable.
  - On resp_ready, go to IDLE on the next edge.
- **kill:** in any non-IDLE state, go to IDLE next cycle; no response is ever issued for the killed operation. kill in IDLE has no effect, and a request presented in the same cycle as kill is not accepted.
- **Reset:** state=IDLE, resp_valid=0, resp_data=0, counter=0. req_ready is 0 while rst is high and 1 in the cycle after rst deasserts.
- **Reset mid-operation:** identical to kill; the result is discarded.

## Timing
- Accept at edge 0.
- Normal op:
  - CALC occupies cycles 1..WIDTH.
  - FIXUP is cycle WIDTH+1.
  - resp_valid rises in cycle WIDTH+2, which is 34 for WIDTH=32.
- Special case: resp_valid rises in cycle 1.
- Minimum request-to-request spacing is latency + 2 cycles, because DONE→IDLE takes one cycle and req_ready is low outside IDLE.
- There is no combinational path from req_* to resp_*, and none from resp_ready to req_ready.
- resp_data is registered and changes only on entry to DONE; it holds its last value in IDLE.

## Structure
- **Shared package:**
  - divOp_t enum, 2 bits, next to adderOp_t.
  - Helper functions is_signed_div(op) and is_rem_op(op).
  - DIV_LATENCY = WIDTH+2 constant, for scoreboard and stall logic.
- **Sub-module div_step:** combinational, one restoring iteration.
  - Inputs: rem, quot, divisor.
  - Outputs: rem_next, quot_next.
  - Instantiated once in CALC; unit-testable on its own.
- The remaining FSM, operand conditioning and fixup logic live in div_unit.

## Test plan
- DIVU 100/7 → 14 (0x0000000E); REMU 100/7 → 2; resp_valid exactly 34 cycles after accept.
- DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); REM 7/−2 → 1; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM −5/0 → 0xFFFFFFFB.
  - resp_valid one cycle after accept.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; one-cycle latency.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE.
  - resp_valid and resp_data stay stable and req_ready=0.
  - After the handshake, req_ready=1 the next cycle and a new request is accepted.
- Abort: assert kill in CALC cycle 10, and separately assert rst in FIXUP.
  - No resp_valid follows in either case.
  - req_ready=1 the following cycle.
  - A subsequent DIVU 9/3 returns 3 with full latency.
